// File: rtl/c1_pkg.sv
// rtl/c1_pkg.sv - shared types and select encodings for the C1 share controller
package c1_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Bit i gives the second-level select (S2 = s0) for requester i:
    // requesters 0/1 sit on the A leg, 2/3 on the B leg.
    localparam logic [NREQ-1:0] S0_FOR_REQ   = 4'b1100;
    // Bit i gives the first-level select value (sa for 0/1, sb for 2/3).
    localparam logic [NREQ-1:0] LEAF_FOR_REQ = 4'b1010;

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/c1_share_ctrl_rr_arb4.sv
// rtl/c1_share_ctrl_rr_arb4.sv - combinational four-way round-robin pick
module rr_arb4
    import c1_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      gnt_idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [1:0]        off;

    // Rotate so the pointer position becomes bit 0, then take the lowest set bit.
    assign dbl = {req, req};
    assign rot = dbl[ptr +: NREQ];

    // Priority encode the rotated request vector.
    always_comb begin
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign gnt_idx = ptr + off;
    assign any     = |req;

endmodule

// File: rtl/c1_share_ctrl.sv
// rtl/c1_share_ctrl.sv - round-robin time-sharing controller for one C1 mux cell
module c1_share_ctrl
    import c1_pkg::*;
#(
    parameter int SIZE   = 5,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [SIZE-1:0] f_in,
    output logic            sa,
    output logic            sb,
    output logic            s0,
    output logic            s1,
    output logic [3:0]      ack,
    output logic [SIZE-1:0] dout,
    output logic            dout_valid,
    output logic            busy
);

    // Counter is loaded with SETTLE-1 so capture lands on the SETTLE-th edge.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] ptr;
    logic [1:0] gnt;
    logic [1:0] pick_idx;
    logic       pick_any;

    rr_arb4 u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign busy = (state != ST_IDLE);

    // Transaction FSM: grant and drive selects, wait out the cell delay, capture and ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            ptr        <= 2'd0;
            gnt        <= 2'd0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            ack        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            s1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        s0 <= S0_FOR_REQ[pick_idx];
                        // Only the leaf select on the chosen leg moves; the other leg is left alone.
                        if (S0_FOR_REQ[pick_idx]) begin
                            sb <= LEAF_FOR_REQ[pick_idx];
                        end else begin
                            sa <= LEAF_FOR_REQ[pick_idx];
                        end
                        cnt   <= CNT_LOAD;
                        gnt   <= pick_idx;
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        dout       <= f_in;
                        ack        <= onehot(gnt);
                        dout_valid <= 1'b1;
                        ptr        <= gnt + 2'd1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ack        <= '0;
                    dout_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    ack        <= '0;
                    dout_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c1_share_ctrl.sv
// tb/tb_c1_share_ctrl.sv - scoreboard bench for c1_share_ctrl
module tb_c1_share_ctrl;

    localparam int SIZE   = 5;
    localparam int SETTLE = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req = 4'b0000;
    logic [SIZE-1:0] f_in;
    logic            sa, sb, s0, s1;
    logic [3:0]      ack;
    logic [SIZE-1:0] dout;
    logic            dout_valid;
    logic            busy;

    logic [SIZE-1:0] data [4];
    logic [SIZE-1:0] a_path, b_path;

    logic rst_q = 1'b1;
    int   cyc   = 0;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int              g;
        logic [SIZE-1:0] d;
        logic            esa;
        logic            esb;
        logic            es0;
        int              ecyc;
    } exp_t;

    exp_t q[$];

    // reference model state
    int              k;
    int              m_ptr;
    logic            m_sa, m_sb, m_s0;
    logic            infl;
    int              infl_g;
    logic            ovr_en;
    logic [SIZE-1:0] ovr_val;

    c1_share_ctrl #(.SIZE(SIZE), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .f_in       (f_in),
        .sa         (sa),
        .sb         (sb),
        .s0         (s0),
        .s1         (s1),
        .ack        (ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // C1 cell: first level picks within each leg, second level picks the leg
    assign a_path = sa ? data[1] : data[0];
    assign b_path = sb ? data[3] : data[2];
    assign f_in   = (s0 | s1) ? b_path : a_path;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: when the controller is free and any request is up, the winner is
    // the first requester at or after the pointer; ack follows SETTLE edges later
    // and the controller is free again two edges after that.
    task automatic model_step();
        if (k == 0) begin
            if (req != 4'b0000) begin
                int g;
                exp_t e;
                g = -1;
                for (int j = 0; j < 4; j++)
                    if (g < 0 && req[(m_ptr + j) % 4]) g = (m_ptr + j) % 4;
                m_s0 = (g >= 2);
                if (g < 2) m_sa = 1'(g % 2);
                else       m_sb = 1'(g % 2);
                e.g    = g;
                e.d    = data[g];
                e.esa  = m_sa;
                e.esb  = m_sb;
                e.es0  = m_s0;
                e.ecyc = cyc + 1 + SETTLE;
                q.push_back(e);
                m_ptr  = (g + 1) % 4;
                k      = SETTLE + 1;
                infl   = 1'b1;
                infl_g = g;
            end
        end else begin
            k--;
            if (k == 0) infl = 1'b0;
        end
    endtask

    // One cycle of stimulus applied on the falling edge.
    task automatic apply(input logic [3:0] set, input logic [3:0] clr, input logic do_rst);
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (ack[i]) req[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (set[i] && !req[i] && !(infl && infl_g == i)) begin
                data[i] = ovr_en ? ovr_val : SIZE'($urandom);
                req[i]  = 1'b1;
            end
        end
        req = req & ~clr;
        rst = do_rst;
        if (do_rst) begin
            k      = 0;
            m_ptr  = 0;
            m_sa   = 1'b0;
            m_sb   = 1'b0;
            m_s0   = 1'b0;
            infl   = 1'b0;
            q.delete();
        end else begin
            model_step();
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && (k != 0 || req != 4'b0000); n++) apply(4'b0000, 4'b0000, 1'b0);
        if (k != 0 || req != 4'b0000) check("drain_bound", 0, 1);
    endtask

    // Monitor: pops the scoreboard on every ack and checks hold/idle behaviour otherwise.
    initial begin
        int              wait_cnt;
        logic            idle_chk;
        logic [SIZE-1:0] last;
        exp_t            e;
        wait_cnt = 0;
        idle_chk = 1'b0;
        last     = '0;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                check("rst_dout", dout, 0);
                check("rst_ack", ack, 0);
                check("rst_dout_valid", dout_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_selects", {sa, sb, s0, s1}, 0);
                last     = '0;
                idle_chk = 1'b0;
                wait_cnt = 0;
            end else begin
                if (idle_chk) begin
                    check("busy_after_done", busy, 0);
                    check("ack_one_cycle", ack, 0);
                    idle_chk = 1'b0;
                end
                if (ack != 4'b0000 || dout_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_ack", ack, 0);
                    end else begin
                        e = q.pop_front();
                        check("ack_grant", ack, 1 << e.g);
                        check("dout_valid", dout_valid, 1);
                        check("dout_value", dout, e.d);
                        check("ack_cycle", cyc, e.ecyc);
                        check("sel_s0", s0, e.es0);
                        check("sel_sa", sa, e.esa);
                        check("sel_sb", sb, e.esb);
                        check("sel_s1", s1, 0);
                        check("busy_in_done", busy, 1);
                        last = e.d;
                    end
                    idle_chk = 1'b1;
                    wait_cnt = 0;
                end else begin
                    check("dout_hold", dout, last);
                    if (q.size() != 0) begin
                        wait_cnt++;
                        if (wait_cnt > 2 * SETTLE + 8) begin
                            check("ack_timeout", 0, 1);
                            void'(q.pop_front());
                            wait_cnt = 0;
                        end
                    end else begin
                        wait_cnt = 0;
                    end
                end
            end
        end
    end

    // Stimulus sequence
    initial begin
        for (int i = 0; i < 4; i++) data[i] = '0;
        k = 0; m_ptr = 0; m_sa = 1'b0; m_sb = 1'b0; m_s0 = 1'b0;
        infl = 1'b0; infl_g = 0; ovr_en = 1'b0; ovr_val = '0;

        // reset held two cycles with all requests up, then full round robin 0,1,2,3
        apply(4'b1111, 4'b0000, 1'b1);
        apply(4'b0000, 4'b0000, 1'b1);
        wait_idle();

        // pointer wrap: after 3 was served, 0 wins over 3
        apply(4'b1001, 4'b0000, 1'b0);
        wait_idle();

        // late withdrawal of 1 and late arrival of 2 during SETTLE
        apply(4'b0010, 4'b0000, 1'b0);
        apply(4'b0100, 4'b0010, 1'b0);
        wait_idle();

        // single request on B0 with a known value
        ovr_en  = 1'b1;
        ovr_val = 5'h15;
        apply(4'b0100, 4'b0000, 1'b0);
        ovr_en  = 1'b0;
        wait_idle();

        // reset while cnt = 1: transaction for 3 aborted, held requests re-served from ptr 0
        apply(4'b1100, 4'b0000, 1'b0);
        apply(4'b0000, 4'b0000, 1'b1);
        wait_idle();

        // random traffic with arrivals, withdrawals and one reset
        for (int n = 0; n < 400; n++) begin
            logic [3:0] s, c;
            s = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0000;
            c = ($urandom % 12 == 0) ? 4'(1 << ($urandom % 4)) : 4'b0000;
            apply(s, c, (n == 200));
        end
        wait_idle();

        // continuous round robin again from the current pointer
        apply(4'b1111, 4'b0000, 1'b0);
        wait_idle();

        apply(4'b0000, 4'b0000, 1'b0);
        apply(4'b0000, 4'b0000, 1'b0);
        check("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
